int_add_err_monitor: RTL
========================

Name: int_add_err_monitor

Overview:
Stimulus and checking front-end for the truncated integer adder (unconfig_int_add). It accepts operand pairs over a valid/ready stream and drives them onto the adder's a/b ports. It tracks the adder's fixed pipeline latency, captures each result on c and compares it against an exact full-width sum. Error statistics are accumulated per run for approximate-computing characterisation. The adder's active-low reset is tied to ~rst at integration.

Parameters:
OP_BITWIDTH, 32, significant MSBs the adder actually computes
DATA_PATH_BITWIDTH, 32, operand/result register width
ADD_LATENCY, 2, adder clock edges from a/b change to c update (input reg + output reg)
CNT_WIDTH, 16, width of operation and error counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
num_ops  input  CNT_WIDTH  operations in the run; latched on start
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts an operand pair
in_a  input  DATA_PATH_BITWIDTH  operand a
in_b  input  DATA_PATH_BITWIDTH  operand b
add_a  output  DATA_PATH_BITWIDTH  to adder a, registered
add_b  output  DATA_PATH_BITWIDTH  to adder b, registered
add_c  input  DATA_PATH_BITWIDTH  from adder c
res_valid  output  1  one-cycle pulse per retired operation
res_c  output  DATA_PATH_BITWIDTH  captured approximate sum
res_err  output  DATA_PATH_BITWIDTH+1  signed error, exact - approximate
err_cnt  output  CNT_WIDTH  results with nonzero error; saturating
max_abs_err  output  DATA_PATH_BITWIDTH  largest |res_err| in the run
busy  output  1  state is RUN or DRAIN
done  output  1  one-cycle pulse at end of run

Behaviour:
- Reset: state IDLE. All outputs 0: add_a, add_b, res_*, stats, busy, done, in_ready. Delay line cleared, so in-flight operations are discarded. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches num_ops, clears err_cnt, max_abs_err and counters. Goes to DONE if num_ops==0, otherwise to RUN. start in any other state is ignored.
  - RUN: in_ready=1. Accept = in_valid & in_ready. When the accept makes issued==num_ops, go to DRAIN the same edge.
  - DRAIN: in_ready=0. Go to DONE when retired==num_ops.
  - DONE: done=1 for exactly one cycle, then IDLE. Stats hold until the next start.
- Accept at edge E0:
  - add_a/add_b <= in_a/in_b; they hold when there is no accept.
  - Exact sum (in_a+in_b) mod 2^DATA_PATH_BITWIDTH and a valid tag enter a delay line of depth ADD_LATENCY.
- Tag exits at edge E0+ADD_LATENCY: add_c is then the adder result.
  - At edge E0+ADD_LATENCY+1: res_c<=add_c and res_err<=exact-add_c, both zero-extended to DATA_PATH_BITWIDTH+1 and subtracted. res_valid=1; retired increments.
  - Accept-to-res_valid latency is ADD_LATENCY+1 cycles. Back-to-back accepts give back-to-back results, in order.
- Stats update on res_valid:
  - err_cnt increments if res_err!=0 and saturates at all-ones.
  - max_abs_err = max(max_abs_err, |res_err| truncated to DATA_PATH_BITWIDTH).
- Both the exact and the approximate sums wrap modulo 2^DATA_PATH_BITWIDTH independently. Carry-out is never reported.
- Bubbles (in_valid=0) in RUN insert no tag and produce no res_valid.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN/DONE) and the default ADD_LATENCY constant, reused by future sub/mul monitors.
- One sub-module, int_err_delay_line: a parameterised shift register of {valid, exact_sum}, depth ADD_LATENCY, with synchronous clear.

Test Plan:
- OP=DPW=32; 4 ops, including a=0xFFFF_FFFF,b=1 -> res_c=0, res_err=0 each; err_cnt=0; done 1 cycle after the last res_valid.
- OP=16, DPW=32; a=0x0001_FFFF, b=0x0000_0001 -> res_c=0x0001_0000, res_err=+0x1_0000, err_cnt=1, max_abs_err=0x0001_0000.
- OP=16; a=0xFFFF_0000, b=0x0001_0000 -> res_c=0, res_err=0 (both wrap); err_cnt unchanged.
- num_ops=0 with start -> no in_ready, done pulses on the 2nd cycle after start, stats=0.
- num_ops=3, in_valid 1,0,0,1,1 -> exactly 3 res_valid, each ADD_LATENCY+1 cycles after its accept, in order.
- rst asserted with 2 ops in flight -> no res_valid or done afterwards; all outputs 0; a new start runs cleanly.

Source files
------------

// File: rtl/int_add_err_monitor_pkg.sv
// Shared definitions for the integer error monitors.
// Holds the run FSM encoding and the default adder pipeline latency.
package int_add_err_monitor_pkg;

  // Default clock edges from operand change to result update:
  // one input register plus one output register inside the adder.
  localparam int DEF_ADD_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mon_state_e;

endpackage

// File: rtl/int_err_delay_line.sv
// Shift register carrying {valid, exact_sum} alongside the adder pipe.
// Ports: clk, clr (sync clear), in_valid/in_data, out_valid/out_data.
module int_err_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/int_add_err_monitor.sv
// Stimulus/check front-end for the truncated integer adder.
// Ports: clk, rst (sync, high), start/num_ops run control,
// in_valid/in_ready/in_a/in_b operand stream, add_a/add_b/add_c
// adder interface, res_valid/res_c/res_err per-op result,
// err_cnt/max_abs_err run stats, busy, done.
module int_add_err_monitor
  import int_add_err_monitor_pkg::*;
#(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int ADD_LATENCY        = DEF_ADD_LATENCY,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          num_ops,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  output logic [DATA_PATH_BITWIDTH-1:0] add_a,
  output logic [DATA_PATH_BITWIDTH-1:0] add_b,
  input  logic [DATA_PATH_BITWIDTH-1:0] add_c,
  output logic                          res_valid,
  output logic [DATA_PATH_BITWIDTH-1:0] res_c,
  output logic [DATA_PATH_BITWIDTH:0]   res_err,
  output logic [CNT_WIDTH-1:0]          err_cnt,
  output logic [DATA_PATH_BITWIDTH-1:0] max_abs_err,
  output logic                          busy,
  output logic                          done
);

  localparam int DW = DATA_PATH_BITWIDTH;

  if (OP_BITWIDTH < 1 || OP_BITWIDTH > DW) begin : g_bad_op
    $error("OP_BITWIDTH must be in 1..DATA_PATH_BITWIDTH");
  end

  mon_state_e state, state_nx;

  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] issued_inc;
  logic [CNT_WIDTH-1:0] retired;

  logic          accept;
  logic          start_run;
  logic [DW-1:0] exact_in;

  logic          dl_valid;
  logic [DW-1:0] dl_sum;

  // One extra stage: the tag leaves the delay line on the same edge
  // the adder output settles, so it is held here for the capture edge.
  logic          cap_valid;
  logic [DW-1:0] cap_sum;

  logic [DW:0]   err_nx;
  logic          err_neg;
  logic [DW-1:0] abs_nx;

  assign accept     = in_valid & in_ready;
  assign start_run  = (state == ST_IDLE) & start;
  assign issued_inc = issued + 1'b1;
  assign exact_in   = in_a + in_b;

  int_err_delay_line #(
    .DEPTH (ADD_LATENCY),
    .WIDTH (DW)
  ) u_dly (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (accept),
    .in_data   (exact_in),
    .out_valid (dl_valid),
    .out_data  (dl_sum)
  );

  // Both sums are already modulo 2^DW; the difference is taken
  // one bit wider so its sign survives.
  assign err_nx  = {1'b0, cap_sum} - {1'b0, add_c};
  assign err_neg = add_c > cap_sum;
  assign abs_nx  = err_neg ? (add_c - cap_sum)
                           : (cap_sum - add_c);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_ops == '0) state_nx = ST_DONE;
          else               state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && issued_inc == target) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (retired == target) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      target      <= '0;
      issued      <= '0;
      retired     <= '0;
      add_a       <= '0;
      add_b       <= '0;
      cap_valid   <= 1'b0;
      cap_sum     <= '0;
      res_valid   <= 1'b0;
      res_c       <= '0;
      res_err     <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
    end else begin
      state     <= state_nx;
      cap_valid <= dl_valid;
      cap_sum   <= dl_sum;
      res_valid <= cap_valid;

      if (start_run) begin
        target      <= num_ops;
        issued      <= '0;
        retired     <= '0;
        err_cnt     <= '0;
        max_abs_err <= '0;
      end

      if (accept) begin
        add_a  <= in_a;
        add_b  <= in_b;
        issued <= issued_inc;
      end

      if (cap_valid) begin
        res_c   <= add_c;
        res_err <= err_nx;
        retired <= retired + 1'b1;
        if (err_nx != '0 && err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
        if (abs_nx > max_abs_err) begin
          max_abs_err <= abs_nx;
        end
      end
    end
  end

endmodule
